// File: rtl/z88_memctl.sv
// z88_memctl: multi-slot memory sequencer between Blink strobes and async SRAM/EPROM.
//
// One access runs IDLE -> SETUP -> STROBE (WS+1 cycles) -> HOLD -> IDLE. Address, write data,
// slot and direction are latched on acceptance. Inputs that change during an access are
// ignored, and the access always runs its full sequence.
//
// Optional feature: define Z88_MEMCTL_WP_EN to add the wp_mask port. A write to a protected
// slot keeps the normal timing but never asserts mem_we_n, and pulses wp_fault on entry to HOLD.
//
// Ports:
//   clk, reset          master clock, synchronous active-high reset
//   ma, cs_n            Blink address and per-slot chip selects (active low, index 0 wins)
//   rd_n, wr_n, cdo     Blink read/write strobes and CPU write data
//   cdi, wait_n         registered read data and CPU wait request (active low)
//   mem_a, mem_dout     shared device address and write data
//   mem_din             shared device read data
//   mem_ce_n            per-device chip enables, one-hot-low or all high
//   mem_oe_n, mem_we_n  device output/write enables
//   busy                high whenever an access is in progress
//   wp_mask, wp_fault   write-protect bits (macro only) and blocked-write pulse
module z88_memctl #(
  parameter int unsigned NSLOTS = 4,
  parameter int unsigned AW = 19,
  parameter int unsigned WS = 2,
  parameter logic [NSLOTS-1:0] SLOT_PRESENT = {NSLOTS{1'b1}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AW-1:0]     ma,
  input  logic [NSLOTS-1:0] cs_n,
  input  logic              rd_n,
  input  logic              wr_n,
  input  logic [7:0]        cdo,
  output logic [7:0]        cdi,
  output logic              wait_n,
  output logic [AW-1:0]     mem_a,
  output logic [7:0]        mem_dout,
  input  logic [7:0]        mem_din,
  output logic [NSLOTS-1:0] mem_ce_n,
  output logic              mem_oe_n,
  output logic              mem_we_n,
  output logic              busy,
  output logic              wp_fault
`ifdef Z88_MEMCTL_WP_EN
  ,
  input  logic [NSLOTS-1:0] wp_mask
`endif
);

  localparam int unsigned SW = (NSLOTS > 1) ? $clog2(NSLOTS) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] STROBE = 2'd2;
  localparam logic [1:0] HOLD   = 2'd3;

  logic [1:0]        state_q;
  logic [3:0]        cnt_q;
  logic              is_read_q;
  logic              blocked_q;
  logic [7:0]        cdi_q;
  logic              wait_n_q;
  logic [AW-1:0]     mem_a_q;
  logic [7:0]        mem_dout_q;
  logic [NSLOTS-1:0] mem_ce_n_q;
  logic              mem_oe_n_q;
  logic              mem_we_n_q;
  logic              wp_fault_q;

  // Request decode: lowest-index active chip select wins.
  logic          any_cs;
  logic [SW-1:0] req_slot;
  logic          req;
  logic          req_present;
  logic          req_wp;
  logic          released;

  always_comb begin
    any_cs   = 1'b0;
    req_slot = '0;
    for (int unsigned i = 0; i < NSLOTS; i++) begin
      if (!cs_n[i] && !any_cs) begin
        any_cs   = 1'b1;
        req_slot = SW'(i);
      end
    end
  end

  always_comb begin
    req         = any_cs & (~rd_n | ~wr_n);
    req_present = SLOT_PRESENT[req_slot];
    released    = (&cs_n) & rd_n & wr_n;
`ifdef Z88_MEMCTL_WP_EN
    req_wp      = wp_mask[req_slot];
`else
    req_wp      = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      is_read_q  <= 1'b0;
      blocked_q  <= 1'b0;
      cdi_q      <= 8'hFF;
      wait_n_q   <= 1'b1;
      mem_a_q    <= '0;
      mem_dout_q <= '0;
      mem_ce_n_q <= '1;
      mem_oe_n_q <= 1'b1;
      mem_we_n_q <= 1'b1;
      wp_fault_q <= 1'b0;
    end else begin
      wp_fault_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            mem_a_q    <= ma;
            mem_dout_q <= cdo;
            // Both strobes low is treated as a read; the write is dropped.
            is_read_q  <= ~rd_n;
            blocked_q  <= rd_n & req_wp;
            if (req_present) begin
              state_q    <= SETUP;
              mem_ce_n_q <= ~(NSLOTS'(1) << req_slot);
              wait_n_q   <= 1'b0;
            end else begin
              // Unpopulated slot: open-bus data, no device cycle, no CPU wait.
              state_q <= HOLD;
              cdi_q   <= 8'hFF;
            end
          end
        end
        SETUP: begin
          state_q <= STROBE;
          cnt_q   <= 4'(WS);
          if (is_read_q) begin
            mem_oe_n_q <= 1'b0;
          end else if (!blocked_q) begin
            mem_we_n_q <= 1'b0;
          end
        end
        STROBE: begin
          if (cnt_q == 4'd0) begin
            state_q    <= HOLD;
            mem_oe_n_q <= 1'b1;
            mem_we_n_q <= 1'b1;
            wait_n_q   <= 1'b1;
            wp_fault_q <= blocked_q;
            if (is_read_q) begin
              cdi_q <= mem_din;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        HOLD: begin
          if (released) begin
            state_q    <= IDLE;
            mem_ce_n_q <= '1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cdi      = cdi_q;
  assign wait_n   = wait_n_q;
  assign mem_a    = mem_a_q;
  assign mem_dout = mem_dout_q;
  assign mem_ce_n = mem_ce_n_q;
  assign mem_oe_n = mem_oe_n_q;
  assign mem_we_n = mem_we_n_q;
  assign busy     = (state_q != IDLE);
  assign wp_fault = wp_fault_q;

endmodule

// File: tb/tb_z88_memctl.sv
// Scoreboard bench for z88_memctl: the driver pushes the expected outcome of each access,
// a negedge monitor measures each access the DUT performs and compares on completion.
module tb_z88_memctl;
  localparam int NS = 4;
  localparam int AW = 19;
  localparam int WS = 2;
  localparam logic [3:0] PRESENT = 4'b0111;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] ma;
  logic [NS-1:0] cs_n;
  logic          rd_n, wr_n;
  logic [7:0]    cdo, cdi, mem_dout, mem_din;
  logic          wait_n;
  logic [AW-1:0] mem_a;
  logic [NS-1:0] mem_ce_n;
  logic          mem_oe_n, mem_we_n, busy, wp_fault;
`ifdef Z88_MEMCTL_WP_EN
  logic [NS-1:0] wp_mask;
`endif

  always #5 clk = ~clk;

  z88_memctl #(.NSLOTS(NS), .AW(AW), .WS(WS), .SLOT_PRESENT(PRESENT)) dut (
    .clk(clk), .reset(reset), .ma(ma), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .cdo(cdo),
    .cdi(cdi), .wait_n(wait_n), .mem_a(mem_a), .mem_dout(mem_dout), .mem_din(mem_din),
    .mem_ce_n(mem_ce_n), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n), .busy(busy),
    .wp_fault(wp_fault)
`ifdef Z88_MEMCTL_WP_EN
    , .wp_mask(wp_mask)
`endif
  );

  typedef struct {
    logic [NS-1:0] ce_n;
    logic [AW-1:0] a;
    logic [7:0]    dout;
    int            oe_cyc;
    int            we_cyc;
    int            wait_cyc;
    logic [7:0]    cdi;
    int            fault_cyc;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  logic [7:0] model_cdi = 8'hFF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: slot is the lowest active select; a present slot gets WS+1 strobe cycles and
  // WS+2 wait cycles; absent slots return FF with no device cycle.
  task automatic issue(input logic [NS-1:0] cs, input logic r_n, input logic w_n,
                       input logic [AW-1:0] a, input logic [7:0] d, input logic [7:0] din,
                       input logic [NS-1:0] wp, input int hold);
    exp_t e;
    int slot = -1;
    bit rd, blocked;
    int n = 0;
    for (int i = 0; i < NS; i++) if (!cs[i] && slot < 0) slot = i;
    while (busy && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("idle_before_request", {31'd0, busy}, 32'd0);
    rd = !r_n;
    blocked = 1'b0;
`ifdef Z88_MEMCTL_WP_EN
    blocked = !rd && wp[slot];
    wp_mask = wp;
`else
    if (wp != wp) blocked = 1'b1;
`endif
    e.a = a;
    e.dout = d;
    if (PRESENT[slot]) begin
      e.ce_n = 4'hF & ~(4'd1 << slot);
      e.oe_cyc = rd ? WS + 1 : 0;
      e.we_cyc = (!rd && !blocked) ? WS + 1 : 0;
      e.wait_cyc = WS + 2;
      e.cdi = rd ? din : model_cdi;
      e.fault_cyc = blocked ? 1 : 0;
    end else begin
      e.ce_n = 4'hF;
      e.oe_cyc = 0;
      e.we_cyc = 0;
      e.wait_cyc = 0;
      e.cdi = 8'hFF;
      e.fault_cyc = 0;
    end
    model_cdi = e.cdi;
    sb.push_back(e);
    cs_n = cs; rd_n = r_n; wr_n = w_n; ma = a; cdo = d; mem_din = din;
    @(posedge clk); #1;
    // Latched values must win over later input changes.
    ma = AW'($urandom);
    cdo = 8'($urandom);
    repeat (hold - 1) begin
      @(posedge clk); #1;
    end
    cs_n = '1; rd_n = 1'b1; wr_n = 1'b1;
    n = 0;
    while (busy && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("access_completes", {31'd0, busy}, 32'd0);
    mem_din = 8'($urandom);
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_reset_values();
    chk("rst_cdi", {24'd0, cdi}, 32'hFF);
    chk("rst_wait_n", {31'd0, wait_n}, 32'd1);
    chk("rst_ce_n", {28'd0, mem_ce_n}, 32'hF);
    chk("rst_oe_n", {31'd0, mem_oe_n}, 32'd1);
    chk("rst_we_n", {31'd0, mem_we_n}, 32'd1);
    chk("rst_mem_a", {13'd0, mem_a}, 32'd0);
    chk("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_wp_fault", {31'd0, wp_fault}, 32'd0);
  endtask

  // Monitor: measures each access from busy rising to busy falling.
  bit in_acc = 0;
  logic [NS-1:0] ce0;
  logic [AW-1:0] a0;
  logic [7:0] d0;
  int oe_c, we_c, wt_c, f_c;
  bit stable, first_ok;

  always @(negedge clk) begin
    if (reset) begin
      in_acc = 0;
      sb.delete();
    end else if (busy && !in_acc) begin
      in_acc = 1;
      ce0 = mem_ce_n; a0 = mem_a; d0 = mem_dout;
      oe_c = 0; we_c = 0; wt_c = 0; f_c = 0;
      stable = 1;
      first_ok = mem_oe_n && mem_we_n;
    end else if (!busy && in_acc) begin
      exp_t e;
      in_acc = 0;
      if (sb.size() == 0) begin
        chk("unexpected_access", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("ce_n", {28'd0, ce0}, {28'd0, e.ce_n});
        chk("mem_a", {13'd0, a0}, {13'd0, e.a});
        chk("mem_dout", {24'd0, d0}, {24'd0, e.dout});
        chk("oe_cycles", oe_c, e.oe_cyc);
        chk("we_cycles", we_c, e.we_cyc);
        chk("wait_cycles", wt_c, e.wait_cyc);
        chk("cdi", {24'd0, cdi}, {24'd0, e.cdi});
        chk("wp_fault_cycles", f_c, e.fault_cyc);
        chk("addr_ce_stable", {31'd0, stable}, 32'd1);
        chk("strobe_setup", {31'd0, first_ok}, 32'd1);
        chk("idle_ce_n", {28'd0, mem_ce_n}, 32'hF);
      end
    end
    if (!reset && in_acc) begin
      oe_c += int'(!mem_oe_n);
      we_c += int'(!mem_we_n);
      wt_c += int'(!wait_n);
      f_c += int'(wp_fault);
      if (mem_ce_n !== ce0 || mem_a !== a0 || mem_dout !== d0) stable = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [NS-1:0] cs;
    int mode;
    reset = 1'b1; cs_n = '1; rd_n = 1'b1; wr_n = 1'b1; ma = '0; cdo = '0; mem_din = '0;
`ifdef Z88_MEMCTL_WP_EN
    wp_mask = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check_reset_values();
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed cases.
    issue(4'b1101, 1'b0, 1'b1, 19'h12345, 8'h00, 8'hA5, 4'b0000, 2);
    issue(4'b1110, 1'b1, 1'b0, 19'h00042, 8'h3C, 8'h00, 4'b0000, 1);
    issue(4'b1011, 1'b0, 1'b1, 19'h00100, 8'h11, 8'h5A, 4'b0000, 3);
    issue(4'b0110, 1'b0, 1'b1, 19'h00200, 8'h22, 8'hC3, 4'b0000, 3);
    issue(4'b0100, 1'b0, 1'b0, 19'h7FFFF, 8'h99, 8'h81, 4'b0000, 2);
    issue(4'b1001, 1'b1, 1'b0, 19'h00300, 8'h77, 8'h00, 4'b0000, 8);
    issue(4'b0111, 1'b0, 1'b1, 19'h00400, 8'h00, 8'h12, 4'b0000, 2);
    issue(4'b1101, 1'b1, 1'b0, 19'h00500, 8'h66, 8'h00, 4'b0010, 2);
    issue(4'b1110, 1'b1, 1'b0, 19'h00600, 8'h55, 8'h00, 4'b0010, 2);

    // Reset held mid-strobe.
    n = 0;
    while (busy && n < 50) begin
      @(posedge clk); #1; n++;
    end
    cs_n = 4'b1110; rd_n = 1'b0; mem_din = 8'h3D;
    n = 0;
    while (mem_oe_n && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("strobe_reached", {31'd0, mem_oe_n}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_values();
    repeat (2) begin
      @(posedge clk); #1;
    end
    cs_n = '1; rd_n = 1'b1;
    reset = 1'b0;
    model_cdi = 8'hFF;
    @(posedge clk); #1;

    // Randomized accesses.
    for (int k = 0; k < 40; k++) begin
      cs = NS'($urandom_range(0, 14));
      mode = $urandom_range(0, 2);
      issue(cs, mode == 1, mode == 0, AW'($urandom), 8'($urandom), 8'($urandom),
            NS'($urandom), $urandom_range(1, WS + 4));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
